axilite_regbank_v2: RTL and testbench

//  Parametrised AXI4-Lite slave register bank; successor to the fixed 4x32-bit test slave.

---
 rtl/axilite_regbank_v2_pkg.sv | 14 +
 rtl/axilite_regbank_v2_if.sv | 39 +++
 rtl/axilite_regbank_v2_byte_merge.sv | 16 +
 rtl/axilite_regbank_v2.sv | 138 +++++++++++++
 tb/tb_axilite_regbank_v2.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axilite_regbank_v2_pkg.sv
// Shared response codes and address-to-index helper for the AXI4-Lite register bank.
package axilite_regbank_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    // Callers zero-extend the address and pass log2(bytes per word) so one helper serves every width.
    function automatic logic [31:0] reg_index(input logic [63:0] addr, input int unsigned lsb);
        return 32'(addr >> lsb);
    endfunction

endpackage

// File: rtl/axilite_regbank_v2_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the register bank (slave).
interface axilite_regbank_v2_if
    import axilite_regbank_pkg::*;
#(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 4
);
    logic [C_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [C_DATA_WIDTH-1:0]   wdata;
    logic [C_DATA_WIDTH/8-1:0] wstrb;
    logic                      wvalid;
    logic                      wready;
    resp_t                     bresp;
    logic                      bvalid;
    logic                      bready;
    logic [C_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [C_DATA_WIDTH-1:0]   rdata;
    resp_t                     rresp;
    logic                      rvalid;
    logic                      rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axilite_regbank_v2_byte_merge.sv
// Byte-lane merge of new write data into an existing register value.
module axilite_byte_merge #(
    parameter int DW = 32
) (
    input  logic [DW-1:0]   old_d,
    input  logic [DW-1:0]   new_d,
    input  logic [DW/8-1:0] strb,
    output logic [DW-1:0]   merged
);
    always_comb begin
        merged = old_d;
        for (int b = 0; b < DW/8; b++) begin
            if (strb[b]) merged[b*8 +: 8] = new_d[b*8 +: 8];
        end
    end
endmodule

// File: rtl/axilite_regbank_v2.sv
// Parametrised AXI4-Lite control/status register bank with byte strobes, read-only status slots,
// SLVERR on bad or read-only access, and a one-cycle commit pulse per register towards the fabric.
module axilite_regbank_v2
    import axilite_regbank_pkg::*;
#(
    parameter int                    C_DATA_WIDTH = 32,
    parameter int                    C_NUM_REGS   = 4,
    parameter int                    C_ADDR_WIDTH = 4,
    parameter logic [C_NUM_REGS-1:0] C_RO_MASK    = '0
) (
    input  logic                               ACLK,
    input  logic                               ARESETN,
    axilite_regbank_v2_if.slave                s_axi,
    output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_q,
    output logic [C_NUM_REGS-1:0]              reg_wr_pulse,
    input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0] ro_d
);
    localparam int          SW  = C_DATA_WIDTH / 8;
    localparam int unsigned LSB = $clog2(SW);
    localparam int          IW  = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

    logic                    aw_held, w_held, bvalid_q, rvalid_q;
    logic [C_ADDR_WIDTH-1:0] aw_addr_q;
    logic [C_DATA_WIDTH-1:0] w_data_q, rdata_q, rd_data_c;
    logic [SW-1:0]           w_strb_q;
    resp_t                   bresp_q, rresp_q, rd_resp_c;
    logic                    aw_hs, w_hs, ar_hs, commit, wr_ok;
    logic [31:0]             wr_idx, rd_idx;
    logic [C_NUM_REGS-1:0]   wr_sel;

    logic [C_DATA_WIDTH-1:0] regs   [C_NUM_REGS];
    logic [C_DATA_WIDTH-1:0] merged [C_NUM_REGS];
    logic [C_DATA_WIDTH-1:0] ro_arr [C_NUM_REGS];

    logic unused_prot;
    assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

    assign s_axi.awready = !aw_held && !bvalid_q;
    assign s_axi.wready  = !w_held && !bvalid_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = !rvalid_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    assign aw_hs  = s_axi.awvalid && s_axi.awready;
    assign w_hs   = s_axi.wvalid && s_axi.wready;
    assign ar_hs  = s_axi.arvalid && s_axi.arready;
    assign commit = aw_held && w_held;

    assign wr_idx = reg_index(64'(aw_addr_q), LSB);
    assign rd_idx = reg_index(64'(s_axi.araddr), LSB);

    always_comb begin
        wr_ok = 1'b0;
        if (wr_idx < 32'(C_NUM_REGS)) wr_ok = !C_RO_MASK[wr_idx[IW-1:0]];
        for (int i = 0; i < C_NUM_REGS; i++) begin
            wr_sel[i] = commit && wr_ok && (wr_idx == 32'(i));
        end
    end

    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg
        axilite_byte_merge #(.DW(C_DATA_WIDTH)) u_merge (
            .old_d  (regs[i]),
            .new_d  (w_data_q),
            .strb   (w_strb_q),
            .merged (merged[i])
        );
        assign reg_q[i*C_DATA_WIDTH +: C_DATA_WIDTH] = regs[i];
        assign ro_arr[i] = ro_d[i*C_DATA_WIDTH +: C_DATA_WIDTH];
    end

    // AW and W are captured independently; the commit edge frees both holding slots and raises B.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held   <= 1'b0;
            aw_addr_q <= '0;
            w_held    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else if (commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_axi.awaddr;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi.wdata;
                w_strb_q <= s_axi.wstrb;
            end
            if (bvalid_q && s_axi.bready) bvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= wr_sel;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (wr_sel[i]) regs[i] <= merged[i];
            end
        end
    end

    // Reads sample the register array before any same-edge commit lands.
    always_comb begin
        rd_data_c = '0;
        rd_resp_c = RESP_SLVERR;
        if (rd_idx < 32'(C_NUM_REGS)) begin
            rd_resp_c = RESP_OKAY;
            rd_data_c = C_RO_MASK[rd_idx[IW-1:0]] ? ro_arr[rd_idx[IW-1:0]] : regs[rd_idx[IW-1:0]];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data_c;
            rresp_q  <= rd_resp_c;
        end else if (rvalid_q && s_axi.rready) begin
            rvalid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axilite_regbank_v2.sv
// Bench for axilite_regbank_v2: three configurations behind one shared stimulus port, table vectors
// plus hand sequences for out-of-order AW/W, held responses and mid-read reset.
module tb_axilite_regbank_v2;
    import axilite_regbank_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int          sel = 0;
    logic [5:0]  awaddr = '0, araddr = '0;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;

    logic        awready_m, wready_m, bvalid_m, arready_m, rvalid_m;
    resp_t       bresp_m, rresp_m;
    logic [63:0] rdata_m;
    logic [7:0]  pulse_m;

    logic [127:0] reg_q_a, reg_q_b;
    logic [511:0] reg_q_c;
    logic [3:0]   pulse_a, pulse_b;
    logic [7:0]   pulse_c;
    logic [127:0] ro_d_b = {32'hDEADBEEF, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};

    axilite_regbank_v2_if #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(5)) ifa ();
    axilite_regbank_v2_if #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(4)) ifb ();
    axilite_regbank_v2_if #(.C_DATA_WIDTH(64), .C_ADDR_WIDTH(6)) ifc ();

    assign ifa.awaddr = awaddr[4:0];  assign ifa.awprot = 3'b000;  assign ifa.awvalid = awvalid && sel == 0;
    assign ifa.wdata = wdata[31:0];   assign ifa.wstrb = wstrb[3:0]; assign ifa.wvalid = wvalid && sel == 0;
    assign ifa.bready = bready && sel == 0;
    assign ifa.araddr = araddr[4:0];  assign ifa.arprot = 3'b000;  assign ifa.arvalid = arvalid && sel == 0;
    assign ifa.rready = rready && sel == 0;

    assign ifb.awaddr = awaddr[3:0];  assign ifb.awprot = 3'b000;  assign ifb.awvalid = awvalid && sel == 1;
    assign ifb.wdata = wdata[31:0];   assign ifb.wstrb = wstrb[3:0]; assign ifb.wvalid = wvalid && sel == 1;
    assign ifb.bready = bready && sel == 1;
    assign ifb.araddr = araddr[3:0];  assign ifb.arprot = 3'b000;  assign ifb.arvalid = arvalid && sel == 1;
    assign ifb.rready = rready && sel == 1;

    assign ifc.awaddr = awaddr;       assign ifc.awprot = 3'b000;  assign ifc.awvalid = awvalid && sel == 2;
    assign ifc.wdata = wdata;         assign ifc.wstrb = wstrb;      assign ifc.wvalid = wvalid && sel == 2;
    assign ifc.bready = bready && sel == 2;
    assign ifc.araddr = araddr;       assign ifc.arprot = 3'b000;  assign ifc.arvalid = arvalid && sel == 2;
    assign ifc.rready = rready && sel == 2;

    axilite_regbank_v2 #(.C_DATA_WIDTH(32), .C_NUM_REGS(4), .C_ADDR_WIDTH(5), .C_RO_MASK(4'b0000)) dut_a (
        .ACLK(clk), .ARESETN(rst_n), .s_axi(ifa), .reg_q(reg_q_a), .reg_wr_pulse(pulse_a), .ro_d(128'd0));
    axilite_regbank_v2 #(.C_DATA_WIDTH(32), .C_NUM_REGS(4), .C_ADDR_WIDTH(4), .C_RO_MASK(4'b1000)) dut_b (
        .ACLK(clk), .ARESETN(rst_n), .s_axi(ifb), .reg_q(reg_q_b), .reg_wr_pulse(pulse_b), .ro_d(ro_d_b));
    axilite_regbank_v2 #(.C_DATA_WIDTH(64), .C_NUM_REGS(8), .C_ADDR_WIDTH(6), .C_RO_MASK(8'h00)) dut_c (
        .ACLK(clk), .ARESETN(rst_n), .s_axi(ifc), .reg_q(reg_q_c), .reg_wr_pulse(pulse_c), .ro_d(512'd0));

    always_comb begin
        awready_m = 1'b0; wready_m = 1'b0; bvalid_m = 1'b0; arready_m = 1'b0; rvalid_m = 1'b0;
        bresp_m = RESP_OKAY; rresp_m = RESP_OKAY; rdata_m = '0; pulse_m = '0;
        case (sel)
            0: begin
                awready_m = ifa.awready; wready_m = ifa.wready; bvalid_m = ifa.bvalid; bresp_m = ifa.bresp;
                arready_m = ifa.arready; rvalid_m = ifa.rvalid; rresp_m = ifa.rresp;
                rdata_m = 64'(ifa.rdata); pulse_m = 8'(pulse_a);
            end
            1: begin
                awready_m = ifb.awready; wready_m = ifb.wready; bvalid_m = ifb.bvalid; bresp_m = ifb.bresp;
                arready_m = ifb.arready; rvalid_m = ifb.rvalid; rresp_m = ifb.rresp;
                rdata_m = 64'(ifb.rdata); pulse_m = 8'(pulse_b);
            end
            default: begin
                awready_m = ifc.awready; wready_m = ifc.wready; bvalid_m = ifc.bvalid; bresp_m = ifc.bresp;
                arready_m = ifc.arready; rvalid_m = ifc.rvalid; rresp_m = ifc.rresp;
                rdata_m = ifc.rdata; pulse_m = pulse_c;
            end
        endcase
    end

    typedef struct packed { logic [63:0] d; resp_t r; } rexp_t;
    resp_t exp_b_q[$];
    rexp_t exp_r_q[$];

    typedef struct { int s; bit wr; logic [5:0] a; logic [63:0] d; logic [7:0] st; resp_t er; logic [7:0] ep; } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_write(input int s, input logic [5:0] a, input logic [63:0] d, input logic [7:0] st,
                            input resp_t er, input logic [7:0] ep, input int hold);
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        int guard = 0;
        resp_t exp = 2'bxx;
        sel = s; awaddr = a; wdata = d; wstrb = st; awvalid = 1'b1; wvalid = 1'b1;
        exp_b_q.push_back(er);
        #1;
        while (!(aw_done && w_done) && guard < 20) begin
            aw_fire = awvalid && awready_m;
            w_fire  = wvalid && wready_m;
            tick(); guard++;
            if (aw_fire) begin awvalid = 1'b0; aw_done = 1; end
            if (w_fire)  begin wvalid = 1'b0; w_done = 1; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_accept", {62'd0, aw_done, w_done}, 64'd3);
        guard = 0;
        while (!bvalid_m && guard < 20) begin tick(); guard++; end
        check("bvalid", bvalid_m, 1);
        if (exp_b_q.size() != 0) exp = exp_b_q.pop_front();
        check("bresp", bresp_m, exp);
        check("wr_pulse", pulse_m, ep);
        repeat (hold) begin
            tick();
            check("bvalid_hold", bvalid_m, 1);
            check("bresp_hold", bresp_m, exp);
            check("awready_blocked", awready_m, 0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bvalid_clear", bvalid_m, 0);
        check("pulse_clear", pulse_m, 0);
    endtask

    task automatic do_read(input int s, input logic [5:0] a, input logic [63:0] ed, input resp_t er, input int hold);
        int guard = 0;
        rexp_t exp = 'x;
        sel = s; araddr = a; arvalid = 1'b1;
        exp_r_q.push_back('{d: ed, r: er});
        #1;
        while (!arready_m && guard < 20) begin tick(); guard++; end
        check("ar_accept", arready_m, 1);
        tick();
        arvalid = 1'b0;
        guard = 0;
        while (!rvalid_m && guard < 20) begin tick(); guard++; end
        check("rvalid", rvalid_m, 1);
        if (exp_r_q.size() != 0) exp = exp_r_q.pop_front();
        check("rdata", rdata_m, exp.d);
        check("rresp", rresp_m, exp.r);
        repeat (hold) begin
            tick();
            check("rvalid_hold", rvalid_m, 1);
            check("rdata_hold", rdata_m, exp.d);
            check("rresp_hold", rresp_m, exp.r);
            check("arready_blocked", arready_m, 0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rvalid_clear", rvalid_m, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // sel, wr, addr, data (or expected read data), strb, resp, pulse
        tbl.push_back('{0, 1, 6'h00, 64'h1,        8'hF, RESP_OKAY,   8'h01});
        tbl.push_back('{0, 1, 6'h04, 64'h2,        8'hF, RESP_OKAY,   8'h02});
        tbl.push_back('{0, 1, 6'h08, 64'h3,        8'hF, RESP_OKAY,   8'h04});
        tbl.push_back('{0, 1, 6'h0C, 64'h4,        8'hF, RESP_OKAY,   8'h08});
        tbl.push_back('{0, 0, 6'h00, 64'h1,        8'h0, RESP_OKAY,   8'h00});
        tbl.push_back('{0, 0, 6'h04, 64'h2,        8'h0, RESP_OKAY,   8'h00});
        tbl.push_back('{0, 0, 6'h08, 64'h3,        8'h0, RESP_OKAY,   8'h00});
        tbl.push_back('{0, 0, 6'h0C, 64'h4,        8'h0, RESP_OKAY,   8'h00});
        tbl.push_back('{0, 1, 6'h00, 64'h11223344, 8'hF, RESP_OKAY,   8'h01});
        tbl.push_back('{0, 1, 6'h00, 64'hFFFFFFFF, 8'h5, RESP_OKAY,   8'h01});
        tbl.push_back('{0, 0, 6'h00, 64'h11FF33FF, 8'h0, RESP_OKAY,   8'h00});
        tbl.push_back('{0, 1, 6'h05, 64'h55,       8'h0, RESP_OKAY,   8'h02});
        tbl.push_back('{0, 0, 6'h06, 64'h2,        8'h0, RESP_OKAY,   8'h00});
        tbl.push_back('{1, 1, 6'h0C, 64'h12345678, 8'hF, RESP_SLVERR, 8'h00});
        tbl.push_back('{1, 0, 6'h0C, 64'hDEADBEEF, 8'h0, RESP_OKAY,   8'h00});
        tbl.push_back('{1, 1, 6'h08, 64'h77,       8'hF, RESP_OKAY,   8'h04});
        tbl.push_back('{1, 0, 6'h08, 64'h77,       8'h0, RESP_OKAY,   8'h00});
        tbl.push_back('{1, 0, 6'h00, 64'h0,        8'h0, RESP_OKAY,   8'h00});
        tbl.push_back('{2, 1, 6'h38, 64'h0123456789ABCDEF, 8'hFF, RESP_OKAY, 8'h80});
        tbl.push_back('{2, 0, 6'h38, 64'h0123456789ABCDEF, 8'h00, RESP_OKAY, 8'h00});
        tbl.push_back('{2, 1, 6'h38, 64'hFFFFFFFFFFFFFFFF, 8'h0F, RESP_OKAY, 8'h80});
        tbl.push_back('{2, 0, 6'h38, 64'h01234567FFFFFFFF, 8'h00, RESP_OKAY, 8'h00});
        tbl.push_back('{2, 1, 6'h08, 64'hAA,       8'hFF, RESP_OKAY,  8'h02});

        repeat (3) tick();
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check("rst_bvalid", bvalid_m, 0);
            check("rst_rvalid", rvalid_m, 0);
            check("rst_rdata", rdata_m, 0);
            check("rst_pulse", pulse_m, 0);
        end
        check("rst_regs_a", 64'(reg_q_a != 0), 0);
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            if (tbl[i].wr) do_write(tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].st, tbl[i].er, tbl[i].ep, 0);
            else           do_read(tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].er, 0);
        end
        check("reg_q_b2", reg_q_b[95:64], 64'h77);
        check("reg_q_b3_ro", reg_q_b[127:96], 0);
        check("reg_q_a0", reg_q_a[31:0], 64'h11FF33FF);

        // W leads AW by three cycles; B must follow the AW edge by exactly one cycle.
        sel = 0; wdata = 64'hA5A5A5A5; wstrb = 8'hF; wvalid = 1'b1;
        exp_b_q.push_back(RESP_OKAY);
        #1;
        check("w_first_ready", wready_m, 1);
        tick();
        wvalid = 1'b0;
        check("w_held_wready", wready_m, 0);
        repeat (3) tick();
        check("b_before_aw", bvalid_m, 0);
        awaddr = 6'h04; awvalid = 1'b1;
        #1;
        check("late_aw_ready", awready_m, 1);
        tick();
        awvalid = 1'b0;
        check("b_not_yet", bvalid_m, 0);
        tick();
        check("b_after_aw", bvalid_m, 1);
        check("late_pulse", pulse_m, 8'h02);
        check("late_bresp", bresp_m, (exp_b_q.size() != 0) ? exp_b_q.pop_front() : 2'bxx);
        check("late_reg1", reg_q_a[63:32], 64'hA5A5A5A5);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("late_b_clear", bvalid_m, 0);

        do_read(0, 6'h10, 64'h0, RESP_SLVERR, 5);
        do_write(0, 6'h10, 64'h99, 8'hF, RESP_SLVERR, 8'h00, 5);
        do_read(0, 6'h04, 64'hA5A5A5A5, RESP_OKAY, 0);

        // Reset lands while a read response is waiting on RREADY.
        do_write(2, 6'h38, 64'hFEEDFACE00000001, 8'hFF, RESP_OKAY, 8'h80, 0);
        sel = 2; araddr = 6'h38; arvalid = 1'b1; rready = 1'b0;
        exp_r_q.push_back('{d: 64'hFEEDFACE00000001, r: RESP_OKAY});
        tick();
        arvalid = 1'b0;
        check("rvalid_pre_rst", rvalid_m, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rvalid_at_rst", rvalid_m, 0);
        check("regs_c_at_rst", 64'(reg_q_c != 0), 0);
        check("pulse_at_rst", pulse_m, 0);
        exp_r_q.delete();
        exp_b_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) do_read(2, 6'(i * 8), 64'h0, RESP_OKAY, 0);
        do_read(0, 6'h00, 64'h0, RESP_OKAY, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
